// File: rtl/uart_rx.sv
// uart_rx: 8N1-style UART receiver with a built-in receive FIFO.
//
// The async serial line goes through a 2-FF synchronizer. A falling edge starts
// a frame. The start bit is re-checked at mid-bit to reject glitches. Data bits
// are taken LSB first and written into a DWIDTH x FDEPTH FIFO that the CPU reads.
//
// Ports:
//   clk        single clock, all logic on posedge
//   rst        synchronous, active-high reset
//   sIn        async serial line, idles high
//   dataRen    pop request, ignored while fifoEmpty=1
//   data       FIFO head, valid the cycle after an accepted pop
//   fifoEmpty  no received bytes pending
//   errClr     clears frameErr and overrun; wins over a set in the same cycle
//   frameErr   sticky: a stop bit was sampled low
//   overrun    sticky: a good frame was dropped because the FIFO was full
//
// Optional feature macro: UART_RX_MAJORITY_EN
//   When defined, every bit decision is the 2-of-3 vote of the synced line at
//   mid-1, mid and mid+1, taken one cycle later than the single-sample build.

module uart_rx #(
  parameter int unsigned DIV    = 16,
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned FDEPTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sIn,
  input  logic              dataRen,
  output logic [DWIDTH-1:0] data,
  output logic              fifoEmpty,
  input  logic              errClr,
  output logic              frameErr,
  output logic              overrun
);

  localparam int unsigned CntW  = $clog2(DIV);
  localparam int unsigned BitW  = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;
  localparam int unsigned PtrW  = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;
  localparam int unsigned CntFW = $clog2(FDEPTH + 1);

`ifdef UART_RX_MAJORITY_EN
  // Vote needs the mid+1 sample, so the start-bit decision moves one cycle later.
  localparam logic [CntW-1:0] HalfLast = CntW'(DIV / 2);
`else
  localparam logic [CntW-1:0] HalfLast = CntW'(DIV / 2 - 1);
`endif
  localparam logic [CntW-1:0]  BitLast = CntW'(DIV - 1);
  localparam logic [BitW-1:0]  LastBit = BitW'(DWIDTH - 1);
  localparam logic [PtrW-1:0]  PtrLast = PtrW'(FDEPTH - 1);
  localparam logic [CntFW-1:0] FullCnt = CntFW'(FDEPTH);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  // Synchronizer and line history. All reset to the idle level.
  logic r_sync1, r_sync2, r_prev;
  logic w_bit;

`ifdef UART_RX_MAJORITY_EN
  logic r_prev2;

  always_ff @(posedge clk) begin
    if (rst) r_prev2 <= 1'b1;
    else     r_prev2 <= r_prev;
  end

  assign w_bit = (r_sync2 & r_prev) | (r_sync2 & r_prev2) | (r_prev & r_prev2);
`else
  assign w_bit = r_sync2;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= sIn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Receive FSM
  state_e            r_state;
  logic [CntW-1:0]   r_cnt;
  logic [BitW-1:0]   r_bit_cnt;
  logic [DWIDTH-1:0] r_shift;
  logic              r_wr_en;
  logic              r_frame_err;
  logic              r_overrun;
  logic [CntFW-1:0]  r_count;
  logic              w_full;

  assign w_full = (r_count == FullCnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_wr_en     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (r_prev && !r_sync2) begin
            r_state <= StStart;
            r_cnt   <= '0;
          end
        end
        StStart: begin
          if (r_cnt == HalfLast) begin
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            // A high line at mid-start is a glitch, not a frame.
            r_state   <= w_bit ? StIdle : StData;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StData: begin
          if (r_cnt == BitLast) begin
            r_cnt   <= '0;
            r_shift <= {w_bit, r_shift[DWIDTH-1:1]};
            if (r_bit_cnt == LastBit) r_state <= StStop;
            else                      r_bit_cnt <= r_bit_cnt + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StStop: begin
          if (r_cnt == BitLast) begin
            r_cnt <= '0;
            if (!w_bit) begin
              r_frame_err <= 1'b1;
              r_state     <= StBreak;
            end else begin
              r_state <= StIdle;
              if (w_full) r_overrun <= 1'b1;
              else        r_wr_en   <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StBreak: begin
          // Hold off until the line returns high so a long break is one error.
          if (r_sync2) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase

      if (errClr) begin
        r_frame_err <= 1'b0;
        r_overrun   <= 1'b0;
      end
    end
  end

  // Receive FIFO
  logic [DWIDTH-1:0] r_mem [FDEPTH];
  logic [PtrW-1:0]   r_wptr, r_rptr;
  logic [DWIDTH-1:0] r_data;
  logic              w_pop;

  assign w_pop = dataRen && (r_count != '0);

  // r_shift is stable for at least one bit time after the stop sample.
  always_ff @(posedge clk) begin
    if (r_wr_en) r_mem[r_wptr] <= r_shift;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_data  <= '0;
    end else begin
      if (r_wr_en) r_wptr <= (r_wptr == PtrLast) ? '0 : r_wptr + 1'b1;
      if (w_pop) begin
        r_data <= r_mem[r_rptr];
        r_rptr <= (r_rptr == PtrLast) ? '0 : r_rptr + 1'b1;
      end
      case ({r_wr_en, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign data      = r_data;
  assign fifoEmpty = (r_count == '0);
  assign frameErr  = r_frame_err;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized scoreboard bench for uart_rx (DIV=16, DWIDTH=8, FDEPTH=4).
// The reference model holds the expected FIFO contents as a queue plus the two
// sticky flags. Pops move the model head into a scoreboard that a separate
// monitor drains whenever the DUT accepts a pop.

module tb_uart_rx;

  localparam int unsigned DIV    = 16;
  localparam int unsigned DWIDTH = 8;
  localparam int unsigned FDEPTH = 4;

  logic       clk = 1'b0;
  logic       rst, sIn, dataRen, errClr;
  logic [7:0] data;
  logic       fifoEmpty, frameErr, overrun;

  uart_rx #(.DIV(DIV), .DWIDTH(DWIDTH), .FDEPTH(FDEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .sIn      (sIn),
    .dataRen  (dataRen),
    .data     (data),
    .fifoEmpty(fifoEmpty),
    .errClr   (errClr),
    .frameErr (frameErr),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cyc      = 0;
  int unsigned start_cyc;

  logic [7:0] model_q[$];
  logic [7:0] exp_q[$];
  logic       exp_ferr = 1'b0;
  logic       exp_ovr  = 1'b0;
  logic       popped   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    popped <= dataRen && !fifoEmpty;
  end

  // Monitor: compare the FIFO head after every accepted pop.
  always @(negedge clk) begin
    if (popped) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL pop_data: got %0h, required no pop (model FIFO empty)", data);
      end else begin
        check("pop_data", data, exp_q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one frame; spike_bit >= 0 inverts that data bit for one cycle at mid-bit.
  task automatic send_frame(input logic [7:0] b, input int stop_low, input int spike_bit);
    start_cyc = cyc;
    sIn = 1'b0;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      sIn = b[i];
      if (spike_bit == i) begin
        tick(DIV / 2);
        sIn = ~b[i];
        tick(1);
        sIn = b[i];
        tick(DIV / 2 - 1);
      end else begin
        tick(DIV);
      end
    end
    if (stop_low > 0) begin
      sIn = 1'b0;
      tick(stop_low);
    end
    sIn = 1'b1;
    tick(DIV);
  endtask

  task automatic expect_rx(input logic [7:0] b);
    if (model_q.size() < FDEPTH) model_q.push_back(b);
    else                         exp_ovr = 1'b1;
  endtask

  task automatic do_pop();
    dataRen = 1'b1;
    if (model_q.size() > 0) exp_q.push_back(model_q.pop_front());
    tick(1);
    dataRen = 1'b0;
    tick(1);
  endtask

  task automatic clear_err();
    errClr = 1'b1;
    tick(1);
    errClr   = 1'b0;
    exp_ferr = 1'b0;
    exp_ovr  = 1'b0;
    tick(1);
  endtask

  task automatic check_flags(input string name);
    check({name, "_frameErr"}, frameErr, exp_ferr);
    check({name, "_overrun"}, overrun, exp_ovr);
    check({name, "_fifoEmpty"}, fifoEmpty, (model_q.size() == 0));
  endtask

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation time limit reached, required $finish before it");
    $fatal(1, "timeout");
  end

  initial begin
    int          lat;
    int          n;
    logic [7:0]  b;

    rst = 1'b1; sIn = 1'b1; dataRen = 1'b0; errClr = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(100);

    // Reset state
    check_flags("reset");
    check("reset_data", data, 0);

    // Back-to-back frames plus first-push latency
    lat = -1;
    fork
      begin
        send_frame(8'hA5, 0, -1);
        expect_rx(8'hA5);
        send_frame(8'h3C, 0, -1);
        expect_rx(8'h3C);
      end
      begin
        n = 0;
        while (fifoEmpty === 1'b1 && n < 400) begin
          tick(1);
          n++;
        end
        lat = int'(cyc - start_cyc);
      end
    join
    check("latency_150_to_160", (lat >= 150 && lat <= 160), 1'b1);
    tick(4);
    check_flags("b2b");
    do_pop();
    do_pop();
    tick(2);
    check_flags("b2b_drained");

    // Short glitch is rejected, next frame still lands
    sIn = 1'b0;
    tick(3);
    sIn = 1'b1;
    tick(40);
    check_flags("glitch");
    send_frame(8'h55, 0, -1);
    expect_rx(8'h55);
    tick(4);
    check_flags("after_glitch");
    do_pop();

    // Stop bit low -> frameErr, nothing pushed; errClr clears it
    send_frame(8'h81, 40, -1);
    exp_ferr = 1'b1;
    tick(4);
    check_flags("stop_low");
    send_frame(8'h81, 0, -1);
    expect_rx(8'h81);
    tick(4);
    check_flags("after_ferr");
    clear_err();
    check_flags("errclr");
    do_pop();

    // errClr held through a bad stop bit: clear wins over set
    errClr = 1'b1;
    send_frame(8'h12, 40, -1);
    errClr = 1'b0;
    tick(2);
    check_flags("clr_priority");

    // Overfill: 5 frames into a 4-deep FIFO
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 0, -1);
      expect_rx(8'(i));
    end
    tick(4);
    check_flags("overrun");
    for (int i = 0; i < 4; i++) do_pop();
    clear_err();
    check_flags("overrun_clr");

    // Reset during data bit 3
    fork
      send_frame(8'hFF, 0, -1);
      begin
        tick(DIV + 3 * DIV + DIV / 2);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
      end
    join
    model_q.delete();
    exp_ferr = 1'b0;
    exp_ovr  = 1'b0;
    tick(20);
    check_flags("reset_mid");
    check("reset_mid_data", data, 0);
    send_frame(8'h0F, 0, -1);
    expect_rx(8'h0F);
    tick(4);
    check_flags("after_reset");
    do_pop();

    // Random bursts with random gaps; one extra pop on empty must be ignored
    for (int r = 0; r < 4; r++) begin
      n = int'($urandom_range(1, 4));
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom);
        send_frame(b, 0, -1);
        expect_rx(b);
        tick(int'($urandom_range(0, 20)));
      end
      tick(4);
      check_flags("rand_burst");
      for (int k = 0; k <= n; k++) do_pop();
      check_flags("rand_drained");
    end

`ifdef UART_RX_MAJORITY_EN
    // Single-cycle spike in the middle of a 0 bit is outvoted
    send_frame(8'h00, 0, 2);
    expect_rx(8'h00);
    tick(4);
    check_flags("spike");
    do_pop();
`endif

    tick(5);
    check("scoreboard_drained", exp_q.size(), 0);
    check("model_drained", model_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
